addr_req_arbiter: RTL and testbench

Round-robin arbiter that shares the SRAM allocation path among the PORT_NUM `addr_gen` instances. It serialises their address requests and grants exactly one requester at a time. It then collects the winner's occupancy map and forwards it to `sram_ctrl` as a single allocation command. A guard interval follows each allocation so `sram_ctrl` can update `sram_idle_cnt` and `sram_addr` before the next requester samples them.

---
 rtl/addr_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_addr_req_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_req_arbiter.sv
// Round-robin arbiter serialising addr_gen allocation requests into single
// sram_ctrl commands, with a per-grant timeout and a post-command guard gap.
module addr_req_arbiter #(
    parameter int PORT_NUM  = 16,
    parameter int TIMEOUT   = 16,
    parameter int GUARD_CYC = 2,
    localparam int PW       = $clog2(PORT_NUM),
    localparam int SLICE_W  = 517
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [PORT_NUM-1:0]         req_addr,
    output logic [PORT_NUM-1:0]         req_done,
    input  logic [PORT_NUM-1:0]         addr_done,
    input  logic [PORT_NUM*SLICE_W-1:0] addr_use,
    output logic                        alloc_vld,
    output logic [4:0]                  alloc_bank,
    output logic [511:0]                alloc_map,
    output logic [PW-1:0]               alloc_port,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [PW-1:0]               timeout_port,
    output logic [4:0]                  dbg_state
);

    // Handshake: req_addr is a level held by the requester; req_done, alloc_vld
    // and timeout_err are single-cycle registered pulses; addr_done is a
    // single-cycle strobe honoured only from the granted port while in WAIT.

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        GRANT  = 5'b00010,
        WAIT   = 5'b00100,
        COMMIT = 5'b01000,
        GUARD  = 5'b10000
    } state_e;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         grant_idx_q, grant_idx_d;
    logic [PW-1:0]         last_ptr_q, last_ptr_d;
    logic [7:0]            timer_q, timer_d;
    logic [3:0]            guard_q, guard_d;
    logic [PORT_NUM-1:0]   req_done_q, req_done_d;
    logic                  alloc_vld_q, alloc_vld_d;
    logic [4:0]            alloc_bank_q, alloc_bank_d;
    logic [511:0]          alloc_map_q, alloc_map_d;
    logic [PW-1:0]         alloc_port_q, alloc_port_d;
    logic                  busy_q, busy_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [PW-1:0]         timeout_port_q, timeout_port_d;

    logic [PW-1:0]         winner;
    logic [PORT_NUM-1:0]   winner_oh;
    logic [SLICE_W-1:0]    cur_slice;
    int                    idx;

    // Scan downward so the port nearest last_ptr+1 is assigned last and wins.
    always_comb begin
        winner    = last_ptr_q;
        idx       = 0;
        for (int i = PORT_NUM; i >= 1; i--) begin
            idx = (int'(last_ptr_q) + i) % PORT_NUM;
            if (req_addr[idx]) winner = idx[PW-1:0];
        end
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

    assign cur_slice = addr_use[int'(grant_idx_q)*SLICE_W +: SLICE_W];

    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        last_ptr_d     = last_ptr_q;
        timer_d        = timer_q;
        guard_d        = guard_q;
        req_done_d     = '0;
        alloc_vld_d    = 1'b0;
        alloc_bank_d   = alloc_bank_q;
        alloc_map_d    = alloc_map_q;
        alloc_port_d   = alloc_port_q;
        timeout_err_d  = 1'b0;
        timeout_port_d = timeout_port_q;
        case (state_q)
            IDLE: begin
                if (|req_addr) begin
                    state_d     = GRANT;
                    grant_idx_d = winner;
                    req_done_d  = winner_oh;
                end
            end
            GRANT: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (addr_done[grant_idx_q]) begin
                    alloc_bank_d = cur_slice[516:512];
                    alloc_map_d  = cur_slice[511:0];
                    alloc_port_d = grant_idx_q;
                    alloc_vld_d  = 1'b1;
                    state_d      = COMMIT;
                end else if (timer_q == TMO_LAST) begin
                    // Abandon the grant and move the pointer past the stuck port.
                    timeout_err_d  = 1'b1;
                    timeout_port_d = grant_idx_q;
                    last_ptr_d     = grant_idx_q;
                    guard_d        = '0;
                    state_d        = GUARD;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            COMMIT: begin
                last_ptr_d = grant_idx_q;
                guard_d    = '0;
                state_d    = GUARD;
            end
            GUARD: begin
                if (guard_q == GUARD_LAST) state_d = IDLE;
                else guard_d = guard_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            grant_idx_q    <= '0;
            last_ptr_q     <= PW'(PORT_NUM - 1);
            timer_q        <= '0;
            guard_q        <= '0;
            req_done_q     <= '0;
            alloc_vld_q    <= 1'b0;
            alloc_bank_q   <= '0;
            alloc_map_q    <= '0;
            alloc_port_q   <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            timeout_port_q <= '0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            last_ptr_q     <= last_ptr_d;
            timer_q        <= timer_d;
            guard_q        <= guard_d;
            req_done_q     <= req_done_d;
            alloc_vld_q    <= alloc_vld_d;
            alloc_bank_q   <= alloc_bank_d;
            alloc_map_q    <= alloc_map_d;
            alloc_port_q   <= alloc_port_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            timeout_port_q <= timeout_port_d;
        end
    end

    assign req_done     = req_done_q;
    assign alloc_vld    = alloc_vld_q;
    assign alloc_bank   = alloc_bank_q;
    assign alloc_map    = alloc_map_q;
    assign alloc_port   = alloc_port_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign timeout_port = timeout_port_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_addr_req_arbiter.sv
// Directed bench for addr_req_arbiter: single request, round-robin order,
// wrap-around, timeout, spurious strobe and reset during WAIT.
module tb_addr_req_arbiter;
    localparam int N  = 16;
    localparam int SW = 517;

    logic             clk = 1'b0;
    logic             sys_rst;
    logic [N-1:0]     req_addr;
    logic [N-1:0]     req_done;
    logic [N-1:0]     addr_done;
    logic [N*SW-1:0]  addr_use;
    logic             alloc_vld;
    logic [4:0]       alloc_bank;
    logic [511:0]     alloc_map;
    logic [3:0]       alloc_port;
    logic             busy;
    logic             timeout_err;
    logic [3:0]       timeout_port;
    logic [4:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [N-1:0] g_raw[$];
    int           g_cyc[$];
    logic [3:0]   a_port[$];
    int           a_cyc[$];
    logic [3:0]   t_port[$];
    int           t_cyc[$];

    addr_req_arbiter #(.PORT_NUM(16), .TIMEOUT(16), .GUARD_CYC(2)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .req_addr(req_addr), .req_done(req_done),
        .addr_done(addr_done), .addr_use(addr_use), .alloc_vld(alloc_vld),
        .alloc_bank(alloc_bank), .alloc_map(alloc_map), .alloc_port(alloc_port),
        .busy(busy), .timeout_err(timeout_err), .timeout_port(timeout_port),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_slice(input int p, input logic [4:0] bank, input logic [511:0] map);
        addr_use[p*SW +: SW] = {bank, map};
    endtask

    task automatic do_reset();
        sys_rst   = 1'b1;
        req_addr  = '0;
        addr_done = '0;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    // Acts as the addr_gen side: ports in respond strobe addr_done in the
    // cycle after their grant pulse. Records grants, commands and timeouts.
    task automatic run_cycles(input int n, input logic [N-1:0] respond);
        logic [N-1:0] pending;
        pending = '0;
        cyc = 0;
        g_raw.delete(); g_cyc.delete(); a_port.delete(); a_cyc.delete();
        t_port.delete(); t_cyc.delete();
        for (int k = 0; k < n; k++) begin
            step();
            if (req_done != '0) begin g_raw.push_back(req_done); g_cyc.push_back(cyc); end
            if (alloc_vld) begin a_port.push_back(alloc_port); a_cyc.push_back(cyc); end
            if (timeout_err) begin t_port.push_back(timeout_port); t_cyc.push_back(cyc); end
            addr_done = pending;
            pending   = req_done & respond;
        end
        addr_done = '0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; req_addr = '0; addr_done = '0; addr_use = '0;
        step();
        step();
        checks++; if (req_done !== 16'h0) begin errors++; $display("FAIL rst_req_done got %h exp 0000", req_done); end
        checks++; if (alloc_vld !== 1'b0) begin errors++; $display("FAIL rst_alloc_vld got %b exp 0", alloc_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (timeout_err !== 1'b0 || timeout_port !== 4'd0) begin errors++; $display("FAIL rst_timeout got %b/%0d exp 0/0", timeout_err, timeout_port); end
        checks++; if (alloc_port !== 4'd0 || alloc_bank !== 5'd0 || alloc_map !== 512'h0) begin errors++; $display("FAIL rst_alloc_fields got %0d/%0d exp 0/0", alloc_port, alloc_bank); end
        checks++; if (dbg_state !== 5'b00001) begin errors++; $display("FAIL rst_state got %b exp 00001", dbg_state); end
        sys_rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_slice(5, 5'd3, 512'h3C00);
        req_addr = 16'h0020;
        step();
        checks++; if (req_done !== 16'h0020) begin errors++; $display("FAIL single_grant got %h exp 0020", req_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        req_addr = '0;
        step();
        checks++; if (req_done !== 16'h0000) begin errors++; $display("FAIL single_grant_pulse got %h exp 0000", req_done); end
        addr_done = 16'h0020;
        step();
        addr_done = '0;
        checks++; if (alloc_vld !== 1'b1) begin errors++; $display("FAIL single_alloc_vld got %b exp 1", alloc_vld); end
        checks++; if (alloc_bank !== 5'd3) begin errors++; $display("FAIL single_bank got %0d exp 3", alloc_bank); end
        checks++; if (alloc_map !== 512'h3C00) begin errors++; $display("FAIL single_map got %h exp 3c00", alloc_map[31:0]); end
        checks++; if (alloc_port !== 4'd5) begin errors++; $display("FAIL single_port got %0d exp 5", alloc_port); end
        step();
        checks++; if (alloc_vld !== 1'b0) begin errors++; $display("FAIL single_vld_pulse got %b exp 0", alloc_vld); end
        checks++; if (alloc_port !== 4'd5 || alloc_bank !== 5'd3) begin errors++; $display("FAIL single_hold got %0d/%0d exp 5/3", alloc_port, alloc_bank); end
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_g[5];
        exp_g = '{16'h0001, 16'h0008, 16'h8000, 16'h0001, 16'h0008};
        do_reset();
        set_slice(0, 5'd1, 512'h1);
        set_slice(3, 5'd2, 512'h2);
        set_slice(15, 5'd4, 512'h4);
        req_addr = 16'h8009;
        run_cycles(30, 16'h8009);
        req_addr = '0;
        checks++; if (g_raw.size() < 5) begin errors++; $display("FAIL rr_count got %0d exp >=5", g_raw.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < g_raw.size()) begin
                checks++; if (g_raw[i] !== exp_g[i]) begin errors++; $display("FAIL rr_grant%0d got %h exp %h", i, g_raw[i], exp_g[i]); end
                if (i > 0) begin
                    checks++; if (g_cyc[i] - g_cyc[i-1] !== 6) begin errors++; $display("FAIL rr_spacing%0d got %0d exp 6", i, g_cyc[i] - g_cyc[i-1]); end
                end
            end
        end
        checks++; if (a_cyc.size() < 1 || a_cyc[0] !== g_cyc[0] + 2 || a_port[0] !== 4'd0) begin errors++; $display("FAIL rr_first_alloc got %0d entries exp port 0 two cycles after grant", a_cyc.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_addr = 16'h4002;
        run_cycles(14, 16'h4002);
        req_addr = '0;
        checks++; if (g_raw.size() < 2) begin errors++; $display("FAIL wrap_count got %0d exp >=2", g_raw.size()); end
        else begin
            checks++; if (g_raw[0] !== 16'h0002) begin errors++; $display("FAIL wrap_first got %h exp 0002", g_raw[0]); end
            checks++; if (g_raw[1] !== 16'h4000) begin errors++; $display("FAIL wrap_second got %h exp 4000", g_raw[1]); end
        end
        checks++; if (a_port.size() < 2 || a_port[0] !== 4'd1 || a_port[1] !== 4'd14) begin errors++; $display("FAIL wrap_alloc_ports got %0d entries exp ports 1,14", a_port.size()); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_slice(4, 5'd7, 512'hAA);
        req_addr = 16'h0014;
        run_cycles(24, 16'h0010);
        req_addr = '0;
        checks++; if (g_raw.size() < 1 || g_raw[0] !== 16'h0004) begin errors++; $display("FAIL tmo_first_grant got %0d entries exp 0004", g_raw.size()); end
        checks++; if (t_cyc.size() !== 1) begin errors++; $display("FAIL tmo_pulse_count got %0d exp 1", t_cyc.size()); end
        else begin
            checks++; if (t_cyc[0] !== 18) begin errors++; $display("FAIL tmo_cycle got %0d exp 18", t_cyc[0]); end
            checks++; if (t_port[0] !== 4'd2) begin errors++; $display("FAIL tmo_port got %0d exp 2", t_port[0]); end
        end
        checks++; if (g_raw.size() < 2 || g_raw[1] !== 16'h0010 || g_cyc[1] !== 21) begin errors++; $display("FAIL tmo_next_grant got %0d entries exp 0010 at cycle 21", g_raw.size()); end
        checks++; if (a_cyc.size() !== 1 || a_cyc[0] !== 23 || a_port[0] !== 4'd4) begin errors++; $display("FAIL tmo_alloc got %0d entries exp one at cycle 23 port 4", a_cyc.size()); end
        checks++; if (timeout_port !== 4'd2) begin errors++; $display("FAIL tmo_port_hold got %0d exp 2", timeout_port); end
    endtask

    task automatic test_spurious();
        do_reset();
        set_slice(6, 5'd1, 512'hF);
        set_slice(7, 5'd9, 512'hFF);
        req_addr = 16'h0040;
        step();
        checks++; if (req_done !== 16'h0040) begin errors++; $display("FAIL spur_grant got %h exp 0040", req_done); end
        step();
        addr_done = 16'h0080;
        step();
        addr_done = 16'h0040;
        checks++; if (alloc_vld !== 1'b0) begin errors++; $display("FAIL spur_ignored got %b exp 0", alloc_vld); end
        step();
        addr_done = '0;
        req_addr  = '0;
        checks++; if (alloc_vld !== 1'b1) begin errors++; $display("FAIL spur_alloc_vld got %b exp 1", alloc_vld); end
        checks++; if (alloc_port !== 4'd6 || alloc_bank !== 5'd1 || alloc_map !== 512'hF) begin errors++; $display("FAIL spur_cmd got port %0d bank %0d exp port 6 bank 1", alloc_port, alloc_bank); end
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid_wait();
        set_slice(9, 5'd2, 512'h1);
        req_addr = 16'h0200;
        step();
        checks++; if (req_done !== 16'h0200) begin errors++; $display("FAIL rmw_grant got %h exp 0200", req_done); end
        step();
        sys_rst   = 1'b1;
        addr_done = 16'h0200;
        step();
        checks++; if (alloc_vld !== 1'b0 || req_done !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rmw_outputs got vld %b done %h busy %b exp 0", alloc_vld, req_done, busy); end
        checks++; if (alloc_port !== 4'd0 || alloc_bank !== 5'd0 || alloc_map !== 512'h0) begin errors++; $display("FAIL rmw_alloc_clear got port %0d bank %0d exp 0/0", alloc_port, alloc_bank); end
        checks++; if (timeout_err !== 1'b0 || timeout_port !== 4'd0) begin errors++; $display("FAIL rmw_timeout got %b/%0d exp 0/0", timeout_err, timeout_port); end
        sys_rst   = 1'b0;
        addr_done = '0;
        req_addr  = 16'h1208;
        step();
        checks++; if (req_done !== 16'h0008) begin errors++; $display("FAIL rmw_post_grant got %h exp 0008", req_done); end
        req_addr = '0;
        step();
        checks++; if (alloc_vld !== 1'b0) begin errors++; $display("FAIL rmw_no_alloc got %b exp 0", alloc_vld); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
